// File: rtl/stream_mux_n_1_pkg.sv
// Shared definitions for the N:1 valid/ready stream multiplexer.
package stream_mux_n_1_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

endpackage

// File: rtl/stream_mux_n_1_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or above ptr, wrapping N-1 -> 0.
module rr_arbiter_n #(
   parameter int N     = 4,
   parameter int SEL_W = $clog2(N)
) (
   input  logic [N-1:0]     req,
   input  logic [SEL_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [SEL_W-1:0] idx
);

   logic             w_found;
   logic [SEL_W-1:0] w_pos;

   always_comb begin
      grant   = '0;
      idx     = '0;
      w_found = 1'b0;
      w_pos   = '0;
      for (int unsigned k = 0; k < N; k++) begin
         w_pos = SEL_W'((32'(ptr) + k) % N);
         if (!w_found && req[w_pos]) begin
            grant[w_pos] = 1'b1;
            idx          = w_pos;
            w_found      = 1'b1;
         end
      end
   end

endmodule

// File: rtl/stream_mux_n_1.sv
// N:1 valid/ready stream multiplexer with fixed or round-robin selection
// and a single registered output stage.
module stream_mux_n_1
   import stream_mux_n_1_pkg::*;
#(
   parameter int N     = 4,
   parameter int WIDTH = 8,
   parameter int SEL_W = $clog2(N)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               mode,
   input  logic [SEL_W-1:0]   sel,
   input  logic [N-1:0]       in_valid,
   input  logic [N*WIDTH-1:0] in_data,
   output logic [N-1:0]       in_ready,
   output logic               out_valid,
   output logic [WIDTH-1:0]   out_data,
   output logic [SEL_W-1:0]   out_sel,
   input  logic               out_ready
);

   mode_e            w_mode;
   logic             w_load_en;
   logic             w_xfer;
   logic [N-1:0]     w_fix_grant;
   logic [N-1:0]     w_rr_grant;
   logic [SEL_W-1:0] w_rr_idx;
   logic [N-1:0]     w_grant;
   logic [SEL_W-1:0] w_idx;
   logic [WIDTH-1:0] w_data;

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_data;
   logic [SEL_W-1:0] r_out_sel;
   logic [SEL_W-1:0] r_ptr;

   assign w_mode    = mode_e'(mode);
   assign w_load_en = !r_out_valid || out_ready;

   rr_arbiter_n #(
      .N     (N),
      .SEL_W (SEL_W)
   ) u_rr_arbiter (
      .req   (in_valid),
      .ptr   (r_ptr),
      .grant (w_rr_grant),
      .idx   (w_rr_idx)
   );

   // Fixed path: a select outside 0..N-1 matches no channel, so nothing is granted.
   always_comb begin
      w_fix_grant = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (32'(sel) == i) begin
            w_fix_grant[i] = in_valid[i];
         end
      end
   end

   assign w_grant = (w_mode == MODE_RR) ? w_rr_grant : w_fix_grant;

   always_comb begin
      w_data = '0;
      w_idx  = '0;
      for (int unsigned i = 0; i < N; i++) begin
         if (w_grant[i]) begin
            w_data = in_data[i*WIDTH +: WIDTH];
            w_idx  = SEL_W'(i);
         end
      end
   end

   assign in_ready = rst ? '0 : (w_grant & {N{w_load_en}});
   assign w_xfer   = |in_ready;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_sel   <= '0;
         r_ptr       <= '0;
      end else if (w_xfer) begin
         r_out_valid <= 1'b1;
         r_out_data  <= w_data;
         r_out_sel   <= w_idx;
         if (w_mode == MODE_RR) begin
            r_ptr <= (32'(w_idx) == N - 1) ? '0 : w_idx + 1'b1;
         end
      end else if (w_load_en) begin
         r_out_valid <= 1'b0;
      end
   end

   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign out_sel   = r_out_sel;

endmodule
